// File: rtl/decoder_3_8_pkg.sv
// Shared types and constants for the held 3-to-8 decoder.
package decoder_3_8_pkg;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/onehot_dec_3_8.sv
// Pure combinational 3-bit binary to 8-bit one-hot decode.
module onehot_dec_3_8 (
    input  logic [2:0] a,
    output logic [7:0] y
);
    assign y = 8'b1 << a;
endmodule

// File: rtl/decoder_3_8_hold.sv
// 3-to-8 decoder that holds each accepted code for HOLD_CYCLES, then idles GAP_CYCLES.
// Optional parity checking on the code input is enabled by DECODER_3_8_PARITY_EN.
module decoder_3_8_hold
    import decoder_3_8_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] a,
    input  logic       a_valid,
`ifdef DECODER_3_8_PARITY_EN
    input  logic       a_par,
    output logic       err,
`endif
    output logic       a_ready,
    output logic [7:0] y,
    output logic       y_valid
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       dec;
    logic             accept;
    logic             code_ok;

    onehot_dec_3_8 u_dec (
        .a (a),
        .y (dec)
    );

    assign a_ready = en && (state == IDLE);
    assign accept  = a_valid && a_ready;

`ifdef DECODER_3_8_PARITY_EN
    // Even parity over {a, a_par}: a good code has an even number of ones.
    assign code_ok = ~^{a, a_par};
`else
    assign code_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
`ifdef DECODER_3_8_PARITY_EN
            err     <= 1'b0;
`endif
        end else begin
`ifdef DECODER_3_8_PARITY_EN
            err <= accept && !code_ok;
`endif
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                y       <= '0;
                y_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A parity-failing code is consumed but never decoded.
                        if (accept && code_ok) begin
                            state   <= HOLD;
                            cnt     <= HOLD_LOAD;
                            y       <= dec;
                            y_valid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == '0) begin
                            y       <= '0;
                            y_valid <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state <= GAP;
                                cnt   <= GAP_LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        y       <= '0;
                        y_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decoder_3_8_hold.sv
// Directed bench: default (4/1) instance plus a HOLD=1/GAP=0 instance.
module tb_decoder_3_8_hold;
    import decoder_3_8_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [2:0] a, a1;
    logic       a_valid, a_valid1;
    logic       a_ready, a_ready1;
    logic [7:0] y, y1;
    logic       y_valid, y_valid1;
    logic       par_bad;
    int         n_chk = 0;
    int         n_pass = 0;

`ifdef DECODER_3_8_PARITY_EN
    logic a_par, a_par1, err, err1;
    assign a_par  = (^a) ^ par_bad;
    assign a_par1 = ^a1;
`endif

    decoder_3_8_hold dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .a_valid(a_valid),
`ifdef DECODER_3_8_PARITY_EN
        .a_par(a_par), .err(err),
`endif
        .a_ready(a_ready), .y(y), .y_valid(y_valid)
    );

    decoder_3_8_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .a_valid(a_valid1),
`ifdef DECODER_3_8_PARITY_EN
        .a_par(a_par1), .err(err1),
`endif
        .a_ready(a_ready1), .y(y1), .y_valid(y_valid1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; a = '0; a_valid = 1'b0;
        a1 = '0; a_valid1 = 1'b0; par_bad = 1'b0;
        step();
        step();
        chk("rst_y", 32'(y), 32'h00);
        chk("rst_yv", 32'(y_valid), 32'h0);
        chk("rst_cnt", 32'(dut.cnt), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_ready", 32'(a_ready), 32'h1);
        rst = 1'b0;

        // Single code 5: four cycles of 0x20, one gap cycle, then ready.
        a = 3'd5; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("a5_y", 32'(y), 32'h20);
        chk("a5_yv", 32'(y_valid), 32'h1);
        chk("a5_ready", 32'(a_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a5_hold", 32'({y_valid, y}), 32'h120);
        end
        step();
        chk("a5_gap", 32'({y_valid, y}), 32'h000);
        chk("a5_gap_rdy", 32'(a_ready), 32'h0);
        step();
        chk("a5_idle_rdy", 32'(a_ready), 32'h1);
        chk("a5_idle_y", 32'(y), 32'h00);

        // Back-to-back sweep with a_valid held high.
        a_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [7:0] exp_y;
            exp_y = 8'h01 << c;
            a = 3'(c);
            step();
            for (int i = 0; i < 4; i++) begin
                chk("sw_hold", 32'({a_ready, y_valid, y}), 32'({2'b01, exp_y}));
                step();
            end
            chk("sw_gap", 32'({a_ready, y_valid, y}), 32'h000);
            step();
            chk("sw_idle", 32'({a_ready, y_valid, y}), 32'h200);
        end
        a_valid = 1'b0;

        // en dropped in the second hold cycle.
        a = 3'd2; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("en_y", 32'(y), 32'h04);
        step();
        en = 1'b0;
        step();
        chk("en_off_y", 32'({y_valid, y}), 32'h000);
        chk("en_off_st", 32'(dut.state), 32'(IDLE));
        chk("en_off_rdy", 32'(a_ready), 32'h0);
        step();
        chk("en_off_rdy2", 32'(a_ready), 32'h0);
        en = 1'b1;
        #1;
        chk("en_on_rdy", 32'(a_ready), 32'h1);

        // Reset mid-hold, then a fresh accept.
        a = 3'd7; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("r7_y", 32'(y), 32'h80);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r7_rst_y", 32'({y_valid, y}), 32'h000);
        chk("r7_rst_cnt", 32'(dut.cnt), 32'h0);
        chk("r7_rst_st", 32'(dut.state), 32'(IDLE));
        a = 3'd1; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("r1_y", 32'({y_valid, y}), 32'h102);
        repeat (5) step();
        chk("r1_done_rdy", 32'(a_ready), 32'h1);

        // HOLD=1, GAP=0: an accept every second cycle.
        a_valid1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_y;
            a1 = 3'(k + 4);
            exp_y = 8'h01 << (k + 4);
            chk("h1_rdy", 32'(a_ready1), 32'h1);
            step();
            chk("h1_y", 32'({a_ready1, y_valid1, y1}), 32'({2'b01, exp_y}));
            step();
            chk("h1_off", 32'({y_valid1, y1}), 32'h000);
        end
        a_valid1 = 1'b0;

`ifdef DECODER_3_8_PARITY_EN
        // Bad parity is consumed with an err pulse; good parity decodes.
        a = 3'd3; par_bad = 1'b1; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("par_err", 32'(err), 32'h1);
        chk("par_bad_y", 32'({y_valid, y}), 32'h000);
        chk("par_bad_st", 32'(dut.state), 32'(IDLE));
        step();
        chk("par_err_clr", 32'(err), 32'h0);
        par_bad = 1'b0; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("par_ok_y", 32'({y_valid, y}), 32'h108);
        chk("par_ok_err", 32'(err), 32'h0);
        repeat (5) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decoder_3_8_hold.md
DECODER_3_8_HOLD -- requirements
Module: decoder_3_8_hold

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles y stays one-hot per accepted code; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: all-zero cycles forced after each hold; legal range 0..255.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: block enable; low forces idle.
REQ-006 SHALL have port a, input, 3: binary code to decode.
REQ-007 SHALL have port a_valid, input, 1: code on a is valid.
REQ-008 SHALL have port a_ready, output, 1: block can accept a code this cycle.
REQ-009 SHALL have port y, output, 8: registered one-hot output, bit a set.
REQ-010 SHALL have port y_valid, output, 1: high exactly while y is one-hot.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, GAP, encoded in the shared package enum.
REQ-012 SHALL drive a_ready = en and (state == IDLE), combinationally.
REQ-013 SHALL accept a code on a clk edge where a_valid and a_ready are both high.
REQ-014 SHALL, on accept, register y = 8'b1 << a and y_valid = 1 at the same edge: one-cycle latency from accept to output.
REQ-015 SHALL hold y and y_valid stable for exactly HOLD_CYCLES cycles, using a down-counter loaded with HOLD_CYCLES-1.
REQ-016 SHALL, when the hold count reaches 0, clear y to 0 and y_valid to 0 at the next edge.
REQ-017 SHALL, at that same edge, enter GAP if GAP_CYCLES > 0, else IDLE.
REQ-018 SHALL remain in GAP for exactly GAP_CYCLES cycles, with y = 0, then return to IDLE.
REQ-019 SHALL ignore a, a_valid and any code change on a outside IDLE; no queuing.
REQ-020 SHALL, when en is low in any state, return to IDLE and clear y and y_valid at the next edge.
REQ-021 SHALL ensure y is never non-zero while y_valid is low, and never has more than one bit set.
REQ-022 SHALL size the counter as 8 bits; 0 is the terminal value, with no wrap-around.
REQ-023 SHALL, with HOLD_CYCLES = 1 and GAP_CYCLES = 0, accept a new code every 2 cycles.

Reset
REQ-024 SHALL, when rst is high at a clk edge, set state = IDLE, counter = 0, y = 8'h00, y_valid = 0; a_ready then follows en.
REQ-025 SHALL give rst priority over en and accept; reset mid-HOLD or mid-GAP aborts immediately.

Configuration
REQ-026 SHALL, with macro DECODER_3_8_PARITY_EN defined, add input a_par (1 bit, even parity over {a, a_par}) and output err (1 bit).
REQ-027 SHALL, with DECODER_3_8_PARITY_EN defined, handle a parity-failing accept as follows: consume it (handshake completes), leave y at 0, keep state IDLE, and pulse err high for one cycle; err resets to 0.
REQ-028 SHALL, without DECODER_3_8_PARITY_EN, have no a_par or err ports and decode every accepted code.

Structure
REQ-029 SHALL place the FSM state enum typedef and the constant CNT_W = 8 in package decoder_3_8_pkg.
REQ-030 SHALL implement the one-hot generation as a combinational sub-module onehot_dec_3_8 (a -> 8-bit one-hot) instantiated once; the FSM and counter stay in decoder_3_8_hold.

Verification
REQ-031 SHALL cover: defaults, en=1, a=3'd5, a_valid pulse -> next edge y=8'h20, y_valid=1 for 4 cycles, then y=0 for 1 cycle, then a_ready=1.
REQ-032 SHALL cover: sweep a=0..7 back-to-back with a_valid held high -> y = 8'h01, 02, 04 ... 80, each for 4 cycles, separated by a 1-cycle gap, with a_ready low outside IDLE.
REQ-033 SHALL cover: en dropped in cycle 2 of HOLD -> next edge y=0, y_valid=0, state IDLE; a_ready stays low until en returns.
REQ-034 SHALL cover: rst asserted mid-HOLD with a=3'd7 -> next edge y=8'h00, y_valid=0, counter 0; a new a=3'd1 accept after reset gives y=8'h02.
REQ-035 SHALL cover: HOLD_CYCLES=1, GAP_CYCLES=0, continuous valid -> an accept every 2 cycles, y one-hot every other cycle.
REQ-036 SHALL cover: with DECODER_3_8_PARITY_EN, a=3'd3 with a_par=1 -> err=1 one cycle, y stays 0; a_par=0 -> y=8'h08.
